// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the two-port SRAM arbiter.
package sram_arb_pkg;

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   typedef logic port_id_t;

   localparam int WORD_W = 32;
   localparam int HALF_W = 16;

endpackage

// File: rtl/sram_arb_grant.sv
// Two-way grant selection. SRAM_ARB_RR_EN builds a round-robin pointer;
// without it port 0 has fixed priority.
module sram_arb_grant
   import sram_arb_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     req0,
   input  logic     req1,
   input  logic     advance,
   output port_id_t gnt
);

`ifdef SRAM_ARB_RR_EN
   // Port favoured on a tie; flips away from whoever was just granted.
   port_id_t ptr_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= 1'b0;
      end else if (advance) begin
         ptr_reg <= ~gnt;
      end
   end

   always_comb begin
      gnt = 1'b0;
      if (req0 && req1) begin
         gnt = ptr_reg;
      end else if (req1) begin
         gnt = 1'b1;
      end
   end
`else
   logic unused_inputs;
   assign unused_inputs = &{1'b0, clk, rst_n, advance};

   assign gnt = !req0 && req1;
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates two word ports onto a 16-bit SRAM, splitting each word into low/high half cycles.
// Arbitration policy selected by SRAM_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W      = 18,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-2:0] addr0,
   input  logic [ADDR_W-2:0] addr1,
   input  logic [WORD_W-1:0] wdata0,
   input  logic [WORD_W-1:0] wdata1,
   output logic              ready0,
   output logic              ready1,
   output logic [WORD_W-1:0] rdata,
   inout  wire  [HALF_W-1:0] SRAM_DQ,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   port_id_t          gnt;
   logic              grab;
   logic              phase_last;

   port_id_t          port_reg, port_next;
   logic              we_reg, we_next;
   logic [ADDR_W-2:0] addr_reg, addr_next;
   logic [WORD_W-1:0] wdata_reg, wdata_next;

   logic [HALF_W-1:0] lo_half_reg;
   logic [WORD_W-1:0] rdata_reg;
   logic              active;
   logic              strobe_n_reg, strobe_n_next;
   logic              we_n_reg, we_n_next;
   logic              oe_n_reg, oe_n_next;
   logic              dq_oe_reg, dq_oe_next;
   logic [HALF_W-1:0] dq_out_reg, dq_out_next;
   logic [ADDR_W-1:0] sram_addr_reg, sram_addr_next;
   logic              ready0_reg, ready0_next;
   logic              ready1_reg, ready1_next;

   sram_arb_grant u_grant (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (req0),
      .req1    (req1),
      .advance (grab),
      .gnt     (gnt)
   );

   assign phase_last = (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      grab       = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (req0 || req1) begin
               grab       = 1'b1;
               state_next = LO;
               cnt_next   = '0;
            end
         end
         LO: begin
            if (phase_last) begin
               state_next = HI;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         HI: begin
            if (phase_last) begin
               state_next = DONE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      port_next  = port_reg;
      we_next    = we_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      if (grab) begin
         port_next  = gnt;
         we_next    = gnt ? we1 : we0;
         addr_next  = gnt ? addr1 : addr0;
         wdata_next = gnt ? wdata1 : wdata0;
      end

      // Pin values are computed for the upcoming state so they register in step with it.
      active         = (state_next == LO) || (state_next == HI);
      strobe_n_next  = !active;
      we_n_next      = !(active && we_next);
      oe_n_next      = !(active && !we_next);
      dq_oe_next     = active && we_next;
      dq_out_next    = (state_next == HI) ? wdata_next[WORD_W-1:HALF_W] : wdata_next[HALF_W-1:0];
      sram_addr_next = active ? {addr_next, state_next == HI} : sram_addr_reg;
      ready0_next    = (state_next == DONE) && (port_next == 1'b0);
      ready1_next    = (state_next == DONE) && (port_next == 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         port_reg      <= 1'b0;
         we_reg        <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         lo_half_reg   <= '0;
         rdata_reg     <= '0;
         strobe_n_reg  <= 1'b1;
         we_n_reg      <= 1'b1;
         oe_n_reg      <= 1'b1;
         dq_oe_reg     <= 1'b0;
         dq_out_reg    <= '0;
         sram_addr_reg <= '0;
         ready0_reg    <= 1'b0;
         ready1_reg    <= 1'b0;
      end else begin
         port_reg      <= port_next;
         we_reg        <= we_next;
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         strobe_n_reg  <= strobe_n_next;
         we_n_reg      <= we_n_next;
         oe_n_reg      <= oe_n_next;
         dq_oe_reg     <= dq_oe_next;
         dq_out_reg    <= dq_out_next;
         sram_addr_reg <= sram_addr_next;
         ready0_reg    <= ready0_next;
         ready1_reg    <= ready1_next;
         // Low half parks until the high half arrives so rdata updates as one word with ready.
         if (state_reg == LO && phase_last && !we_reg) begin
            lo_half_reg <= SRAM_DQ;
         end
         if (state_reg == HI && phase_last && !we_reg) begin
            rdata_reg <= {SRAM_DQ, lo_half_reg};
         end
      end
   end

   assign SRAM_DQ   = dq_oe_reg ? dq_out_reg : {HALF_W{1'bz}};
   assign SRAM_ADDR = sram_addr_reg;
   assign SRAM_CE_N = strobe_n_reg;
   assign SRAM_UB_N = strobe_n_reg;
   assign SRAM_LB_N = strobe_n_reg;
   assign SRAM_WE_N = we_n_reg;
   assign SRAM_OE_N = oe_n_reg;
   assign ready0    = ready0_reg;
   assign ready1    = ready1_reg;
   assign rdata     = rdata_reg;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter with an SRAM device model and a word-level reference model.
module tb_sram_port_arbiter;

   localparam int AW     = 18;
   localparam int WAIT   = 1;
   localparam int LAT    = 2 * (WAIT + 1) + 1;
   localparam int PERIOD = 2 * (WAIT + 1) + 2;
   localparam int ACT    = 2 * (WAIT + 1);
`ifdef SRAM_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [AW-2:0] addr0 = '0, addr1 = '0;
   logic [31:0]   wdata0 = '0, wdata1 = '0;
   logic          ready0, ready1;
   logic [31:0]   rdata;
   wire  [15:0]   sram_dq;
   logic [AW-1:0] sram_addr;
   logic          sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

   int vec_cnt = 0;
   int err_cnt = 0;

   // SRAM device model
   logic [15:0] sram_mem [0:(1<<AW)-1];
   assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'hzzzz;
   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n) begin
         if (!sram_lb_n) sram_mem[sram_addr][7:0]  <= sram_dq[7:0];
         if (!sram_ub_n) sram_mem[sram_addr][15:8] <= sram_dq[15:8];
      end
   end

   // Word-level reference model
   logic [31:0] exp_mem [int];
   logic [31:0] exp_rdata = '0;
   bit          last_gnt = 1'b1;

   sram_port_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ready0(ready0), .ready1(ready1), .rdata(rdata),
      .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
      .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n), .SRAM_WE_N(sram_we_n),
      .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input int a);
      return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
   endfunction

   task automatic run_access(input bit port, input bit we, input logic [AW-2:0] addr,
                             input logic [31:0] wd, input bit drop_early);
      int lat, we_lo, oe_lo;
      bit got, wrong;
      @(negedge clk);
      if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
      else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
      lat = 0; we_lo = 0; oe_lo = 0; got = 1'b0; wrong = 1'b0;
      while (!got && lat < 4 * LAT) begin
         @(posedge clk); #1;
         lat++;
         if (drop_early && lat == 1) begin
            if (port) req1 = 1'b0; else req0 = 1'b0;
         end
         if (!sram_we_n) we_lo++;
         if (!sram_oe_n) oe_lo++;
         if (port ? ready1 : ready0) got = 1'b1;
         if (port ? ready0 : ready1) wrong = 1'b1;
      end
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      last_gnt = port;
      if (we) exp_mem[int'(addr)] = wd;
      else    exp_rdata = model_word(int'(addr));
      $display("access port=%0d we=%0d addr=%h wdata=%h lat=%0d rdata=%h", port, we, addr, wd, lat, rdata);
      check("latency", lat, LAT);
      check("ready_other", wrong, 0);
      check("rdata", rdata, exp_rdata);
      check("we_n_low_cycles", we_lo, we ? ACT : 0);
      check("oe_n_low_cycles", oe_lo, we ? 0 : ACT);
      if (we) begin
         check("mem_lo", sram_mem[{addr, 1'b0}], wd[15:0]);
         check("mem_hi", sram_mem[{addr, 1'b1}], wd[31:16]);
      end
      @(posedge clk); #1;
      check("ready_pulse", {ready0, ready1}, 2'b00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [AW-2:0] pool [6];
      logic [AW-2:0] a, b, c;
      logic [31:0]   wd;
      int lat, cnt_a, cnt_b;
      bit got, exp_p;

      for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0;
      pool[0] = '0; pool[1] = 'h1; pool[2] = 'h10; pool[3] = 'h55;
      pool[4] = {{(AW-2){1'b1}}, 1'b0}; pool[5] = {(AW-1){1'b1}};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_strobes", {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 5'h1f);
      check("rst_addr", sram_addr, 0);
      check("rst_ready", {ready0, ready1}, 2'b00);
      check("rst_rdata", rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Write then read back a known word
      run_access(1'b1, 1'b1, 'h10, 32'hDEADBEEF, 1'b0);
      run_access(1'b0, 1'b0, 'h10, 32'h0, 1'b0);

      // Top word of the address space must not wrap into word 0
      run_access(1'b1, 1'b1, {(AW-1){1'b1}}, 32'h12345678, 1'b0);
      check("addr0_untouched", sram_mem[0], model_word(0) & 32'hffff);

      // Random single-port traffic
      for (int n = 0; n < 30; n++) begin
         a  = pool[$urandom_range(0, 5)];
         wd = $urandom;
         run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd, 1'b0);
      end

      // Requester drops req one cycle after grant
      run_access(1'b0, 1'b0, 'h55, 32'h0, 1'b1);
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 2 * PERIOD; i++) begin
         @(posedge clk); #1;
         if (!sram_ce_n) cnt_a++;
         if (ready0 || ready1) cnt_b++;
      end
      check("drop_no_second_access", cnt_a, 0);
      check("drop_no_ready", cnt_b, 0);

      // Both ports requesting continuously
      a = 'h77; b = 'h33; wd = $urandom;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = a;
      req1 = 1'b1; we1 = 1'b1; addr1 = b; wdata1 = wd;
      for (int k = 0; k < 4; k++) begin
         lat = 0; got = 1'b0;
         while (!got && lat < 4 * PERIOD) begin
            @(posedge clk); #1;
            lat++;
            if (ready0 || ready1) got = 1'b1;
         end
         exp_p = RR_EN ? !last_gnt : 1'b0;
         last_gnt = exp_p;
         if (exp_p) exp_mem[int'(b)] = wd;
         else       exp_rdata = model_word(int'(a));
         $display("contend grant=%0d ready0=%0d ready1=%0d lat=%0d rdata=%h", k, ready0, ready1, lat, rdata);
         check("arb_order", {ready0, ready1}, exp_p ? 2'b01 : 2'b10);
         check("arb_period", lat, (k == 0) ? LAT : PERIOD);
         check("arb_rdata", rdata, exp_rdata);
      end
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;

      // Reset during the high half of a write
      c = 'h40;
      run_access(1'b1, 1'b1, c, 32'hAAAA5555, 1'b0);
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; addr1 = c; wdata1 = 32'h13572468;
      repeat (WAIT + 2) @(posedge clk);
      #1;
      check("pre_rst_we_n", sram_we_n, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_abort_strobes", {sram_we_n, sram_ce_n, sram_oe_n}, 3'b111);
      req1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cnt_b = 0;
      for (int i = 0; i < 2 * PERIOD; i++) begin
         @(posedge clk); #1;
         if (ready0 || ready1) cnt_b++;
      end
      check("rst_no_ready", cnt_b, 0);
      check("rst_mem_lo", sram_mem[{c, 1'b0}], 16'h2468);
      check("rst_mem_hi", sram_mem[{c, 1'b1}], 16'hAAAA);
      exp_mem[int'(c)] = 32'hAAAA2468;
      exp_rdata = '0;
      last_gnt = 1'b1;
      check("rst_rdata_cleared", rdata, exp_rdata);
      run_access(1'b0, 1'b0, c, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
